// File: rtl/prencoder_rr.sv
// Registered priority encoder with valid/ready handshake; fixed (MSB-first) or round-robin mode per transfer.
// Optional PRENC_ONEHOT_EN adds a registered one-hot copy of the winning index (out_onehot).
module prencoder_rr #(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             out_zero,
    output logic [OUT_W-1:0] ptr
`ifdef PRENC_ONEHOT_EN
    ,
    output logic [WIDTH-1:0] out_onehot
`endif
);

    localparam logic [OUT_W-1:0] LAST_IDX = OUT_W'(WIDTH - 1);
    localparam logic [OUT_W:0]   WIDTH_X  = (OUT_W + 1)'(WIDTH);

    logic             accept;
    logic             in_zero;
    logic [OUT_W-1:0] fix_win;
    logic [OUT_W-1:0] rr_win;
    logic             rr_hit;
    logic [OUT_W-1:0] win;
    logic [OUT_W-1:0] ptr_nxt;

    // Single output register: a new vector may enter whenever the slot is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_zero  = ~|in;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        fix_win = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                fix_win = OUT_W'(i);
            end
        end
    end

    // Ascending search from ptr; the wrap back to bit 0 is an explicit subtract so non-power-of-two widths never touch unused codes.
    always_comb begin
        logic [OUT_W:0] pos;
        rr_win = '0;
        rr_hit = 1'b0;
        pos    = '0;
        for (int k = 0; k < WIDTH; k++) begin
            pos = {1'b0, ptr} + (OUT_W + 1)'(k);
            if (pos >= WIDTH_X) begin
                pos = pos - WIDTH_X;
            end
            if (!rr_hit && in[pos[OUT_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_win = pos[OUT_W-1:0];
            end
        end
    end

    assign win     = mode ? rr_win : fix_win;
    assign ptr_nxt = (rr_win == LAST_IDX) ? '0 : rr_win + OUT_W'(1);

`ifdef PRENC_ONEHOT_EN
    logic [WIDTH-1:0] onehot_d;
    assign onehot_d = in_zero ? '0 : (WIDTH'(1) << win);
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_zero  <= 1'b0;
            ptr       <= '0;
`ifdef PRENC_ONEHOT_EN
            out_onehot <= '0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out       <= in_zero ? '0 : win;
            out_zero  <= in_zero;
            if (mode && !in_zero) begin
                ptr <= ptr_nxt;
            end
`ifdef PRENC_ONEHOT_EN
            out_onehot <= onehot_d;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
